// File: rtl/cdp1802_io_hub.sv
// ============================================================================
// Module  : cdp1802_io_hub
// Brief   : CDP1802 N-line port peripheral: TX/RX FIFOs, sticky status,
//           two output latches and a cycle counter with snapshot reads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cdp1802_io_hub #(
  parameter int FIFO_DEPTH = 8,
  parameter int CC_WIDTH   = 16
) (
  input  logic                clock,
  input  logic                resetq,
  input  logic [2:0]          io_n,
  input  logic                io_inp,
  input  logic                io_out,
  input  logic [7:0]          io_dout,
  output logic [7:0]          io_din,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [7:0]          gpo_a,
  output logic [7:0]          gpo_b,
  output logic [CC_WIDTH-1:0] cc
);

  localparam int             c_aw   = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0]  c_full = FIFO_DEPTH[c_aw:0];

  logic                r_inp_q, r_out_q, r_armed;
  logic [CC_WIDTH-1:0] r_cc, r_snap;
  logic [7:0]          r_gpo_a, r_gpo_b;
  logic                r_tx_ovf, r_rx_ovf;

  logic [7:0]          r_tx_mem [FIFO_DEPTH];
  logic [c_aw-1:0]     r_tx_wp, r_tx_rp;
  logic [c_aw:0]       r_tx_cnt;
  logic [7:0]          r_rx_mem [FIFO_DEPTH];
  logic [c_aw-1:0]     r_rx_wp, r_rx_rp;
  logic [c_aw:0]       r_rx_cnt;

  // r_armed masks the first edge after reset so a strobe held through reset
  // release must drop and rise again before it counts as an access.
  logic w_rd, w_wr;
  assign w_rd = r_armed & io_inp & ~r_inp_q & ~io_out;
  assign w_wr = r_armed & io_out & ~r_out_q & ~io_inp;

  logic w_tx_full, w_tx_push, w_tx_acc, w_tx_pop;
  assign w_tx_full = (r_tx_cnt == c_full);
  assign w_tx_push = w_wr && (io_n == 3'd1);
  assign w_tx_acc  = w_tx_push & ~w_tx_full;
  assign w_tx_pop  = tx_valid & tx_ready;

  logic w_rx_full, w_rx_nonempty, w_rx_acc, w_rx_pop;
  assign w_rx_full     = (r_rx_cnt == c_full);
  assign w_rx_nonempty = (r_rx_cnt != '0);
  assign w_rx_acc      = rx_valid & ~w_rx_full;
  assign w_rx_pop      = w_rd && (io_n == 3'd2) && w_rx_nonempty;

  logic w_clr_tx, w_clr_rx;
  assign w_clr_tx = w_wr && (io_n == 3'd3) && io_dout[3];
  assign w_clr_rx = w_wr && (io_n == 3'd3) && io_dout[2];

  assign tx_valid = (r_tx_cnt != '0);
  assign tx_data  = r_tx_mem[r_tx_rp];
  assign rx_ready = ~w_rx_full;
  assign gpo_a    = r_gpo_a;
  assign gpo_b    = r_gpo_b;
  assign cc       = r_cc;

  logic [7:0] w_status;
  assign w_status = {4'b0000, r_tx_ovf, r_rx_ovf, w_tx_full, w_rx_nonempty};

  always_comb begin
    io_din = 8'h00;
    if (io_inp && !io_out) begin
      case (io_n)
        3'd2:    io_din = w_rx_nonempty ? r_rx_mem[r_rx_rp] : 8'h00;
        3'd3:    io_din = w_status;
        3'd4:    io_din = r_cc[7:0];
        3'd5:    io_din = r_snap[7:0];
        3'd6:    io_din = r_gpo_a;
        3'd7:    io_din = r_gpo_b;
        default: io_din = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_tx_acc) r_tx_mem[r_tx_wp] <= io_dout;
    if (w_rx_acc) r_rx_mem[r_rx_wp] <= rx_data;
  end

  always_ff @(posedge clock or negedge resetq) begin
    if (!resetq) begin
      r_inp_q  <= 1'b0;
      r_out_q  <= 1'b0;
      r_armed  <= 1'b0;
      r_cc     <= '0;
      r_snap   <= '0;
      r_gpo_a  <= 8'h00;
      r_gpo_b  <= 8'h00;
      r_tx_ovf <= 1'b0;
      r_rx_ovf <= 1'b0;
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      r_inp_q <= io_inp;
      r_out_q <= io_out;
      r_armed <= 1'b1;
      r_cc    <= r_cc + CC_WIDTH'(1);

      if (w_tx_acc) r_tx_wp <= r_tx_wp + c_aw'(1);
      if (w_tx_pop) r_tx_rp <= r_tx_rp + c_aw'(1);
      case ({w_tx_acc, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + (c_aw+1)'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - (c_aw+1)'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase

      if (w_rx_acc) r_rx_wp <= r_rx_wp + c_aw'(1);
      if (w_rx_pop) r_rx_rp <= r_rx_rp + c_aw'(1);
      case ({w_rx_acc, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + (c_aw+1)'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - (c_aw+1)'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase

      // Set terms are OR-ed after the clear so a coincident set wins.
      r_tx_ovf <= (r_tx_ovf & ~w_clr_tx) | (w_tx_push & w_tx_full);
      r_rx_ovf <= (r_rx_ovf & ~w_clr_rx) | (rx_valid & w_rx_full);

      if (w_rd && io_n == 3'd4) r_snap <= r_cc >> 8;
      else if (w_rd && io_n == 3'd5) r_snap <= r_snap >> 8;

      if (w_wr && io_n == 3'd6) r_gpo_a <= io_dout;
      if (w_wr && io_n == 3'd7) r_gpo_b <= io_dout;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cdp1802_io_hub.sv
// ============================================================================
// Module  : tb_cdp1802_io_hub
// Brief   : Directed plus randomized bench for cdp1802_io_hub against a
//           queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdp1802_io_hub;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        resetq;
  logic [2:0]  io_n;
  logic        io_inp, io_out;
  logic [7:0]  io_dout, io_din;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  gpo_a, gpo_b;
  logic [15:0] cc;

  always #5 clock = ~clock;

  cdp1802_io_hub #(.FIFO_DEPTH(DEPTH), .CC_WIDTH(16)) dut (
    .clock(clock), .resetq(resetq), .io_n(io_n), .io_inp(io_inp),
    .io_out(io_out), .io_dout(io_dout), .io_din(io_din),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .gpo_a(gpo_a), .gpo_b(gpo_b), .cc(cc)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]  m_tx[$];
  logic [7:0]  m_rx[$];
  logic        m_txo, m_rxo, m_pi, m_po, m_first;
  logic [7:0]  m_ga, m_gb;
  logic [15:0] m_cc, m_snap;
  logic [7:0]  obs_din, obs_tx;
  logic        obs_tv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tx.delete();
    m_rx.delete();
    m_txo = 0; m_rxo = 0; m_pi = 0; m_po = 0; m_first = 1;
    m_ga = 0; m_gb = 0; m_cc = 0; m_snap = 0;
  endtask

  function automatic logic [7:0] exp_din();
    if (!io_inp || io_out) return 8'h00;
    case (io_n)
      3'd2: return (m_rx.size() != 0) ? m_rx[0] : 8'h00;
      3'd3: return {4'b0, m_txo, m_rxo, m_tx.size() == DEPTH, m_rx.size() != 0};
      3'd4: return m_cc[7:0];
      3'd5: return m_snap[7:0];
      3'd6: return m_ga;
      3'd7: return m_gb;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_edge();
    logic rd, wr, tx_in, tx_rej, rx_in, rx_drop;
    rd      = io_inp && !io_out && !m_pi && !m_first;
    wr      = io_out && !io_inp && !m_po && !m_first;
    tx_in   = wr && io_n == 3'd1 && m_tx.size() < DEPTH;
    tx_rej  = wr && io_n == 3'd1 && m_tx.size() >= DEPTH;
    rx_in   = rx_valid && m_rx.size() < DEPTH;
    rx_drop = rx_valid && m_rx.size() >= DEPTH;
    if (m_tx.size() != 0 && tx_ready) void'(m_tx.pop_front());
    if (tx_in) m_tx.push_back(io_dout);
    if (rd && io_n == 3'd2 && m_rx.size() != 0) void'(m_rx.pop_front());
    if (rx_in) m_rx.push_back(rx_data);
    if (wr && io_n == 3'd3) begin
      if (io_dout[3]) m_txo = 0;
      if (io_dout[2]) m_rxo = 0;
    end
    if (tx_rej)  m_txo = 1;
    if (rx_drop) m_rxo = 1;
    if (rd && io_n == 3'd4) m_snap = m_cc >> 8;
    else if (rd && io_n == 3'd5) m_snap = m_snap >> 8;
    if (wr && io_n == 3'd6) m_ga = io_dout;
    if (wr && io_n == 3'd7) m_gb = io_dout;
    m_cc    = m_cc + 16'd1;
    m_pi    = io_inp;
    m_po    = io_out;
    m_first = 0;
  endtask

  // One clock: check outputs mid-cycle, advance the model on the edge.
  task automatic tick();
    @(negedge clock);
    obs_din = io_din;
    obs_tx  = tx_data;
    obs_tv  = tx_valid;
    chk("io_din", io_din, exp_din());
    chk("tx_valid", tx_valid, m_tx.size() != 0);
    if (m_tx.size() != 0) chk("tx_data", tx_data, m_tx[0]);
    chk("rx_ready", rx_ready, m_rx.size() < DEPTH);
    chk("gpo_a", gpo_a, m_ga);
    chk("gpo_b", gpo_b, m_gb);
    chk("cc", cc, m_cc);
    @(posedge clock);
    if (!resetq) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic cpu_out(input logic [2:0] n, input logic [7:0] d);
    io_n = n; io_dout = d; io_out = 1;
    tick();
    io_out = 0;
    tick();
  endtask

  task automatic cpu_inp(input logic [2:0] n, input int hold, output logic [7:0] first);
    io_n = n; io_inp = 1;
    tick();
    first = obs_din;
    repeat (hold - 1) tick();
    io_inp = 0;
    tick();
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] exp_seq [3];
    int guard;
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33;

    resetq = 0; io_n = 0; io_inp = 0; io_out = 0; io_dout = 0;
    tx_ready = 0; rx_data = 0; rx_valid = 0;
    model_reset();
    #1;
    tick(); tick();
    chk("rst_din", io_din, 8'h00);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_rx_ready", rx_ready, 1'b1);
    chk("rst_gpo", {gpo_a, gpo_b}, 16'h0000);
    resetq = 1;
    repeat (5) tick();
    chk("cc_after5", cc, 16'd5);

    // TX ordering
    cpu_out(1, 8'h11); cpu_out(1, 8'h22); cpu_out(1, 8'h33);
    tx_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tx_seq", obs_tx, exp_seq[i]);
    end
    tick();
    chk("tx_drained", obs_tv, 1'b0);
    tx_ready = 0;

    // TX overflow and sticky clear
    for (int i = 0; i < 9; i++) cpu_out(1, 8'h40 + 8'(i));
    cpu_inp(3, 1, r);
    chk("status_ovf", r, 8'h0A);
    cpu_out(3, 8'h08);
    cpu_inp(3, 1, r);
    chk("status_clr", r, 8'h02);
    tx_ready = 1;
    repeat (10) tick();
    tx_ready = 0;

    // RX pops: held strobe counts once
    rx_valid = 1; rx_data = 8'hA5; tick();
    rx_data = 8'h5A; tick();
    rx_valid = 0;
    cpu_inp(2, 3, r); chk("rx_pop1", r, 8'hA5);
    cpu_inp(2, 1, r); chk("rx_pop2", r, 8'h5A);
    cpu_inp(2, 1, r); chk("rx_empty", r, 8'h00);
    cpu_inp(3, 1, r); chk("rx_nonempty_bit", r[0], 1'b0);

    // Snapshot across a carry
    guard = 0;
    while (m_cc != 16'h12FF && guard < 70000) begin tick(); guard++; end
    chk("cc_wait_bound", guard < 70000, 1'b1);
    cpu_inp(4, 1, r); chk("cc_lo", r, 8'hFF);
    repeat (8) tick();
    cpu_inp(5, 1, r); chk("cc_hi_snap", r, 8'h12);

    // Simultaneous strobes are ignored
    io_n = 6; io_dout = 8'h3C; io_inp = 1; io_out = 1;
    tick();
    chk("both_din", obs_din, 8'h00);
    io_inp = 0; io_out = 0;
    tick();
    chk("both_gpo_a", gpo_a, 8'h00);
    cpu_out(6, 8'h3C);
    chk("gpo_a_wr", gpo_a, 8'h3C);
    cpu_inp(6, 1, r); chk("gpo_a_rd", r, 8'h3C);

    // Reset mid-access, strobe held across release
    cpu_out(7, 8'h77);
    chk("gpo_b_wr", gpo_b, 8'h77);
    io_n = 7; io_dout = 8'h99; io_out = 1;
    resetq = 0;
    #1;
    chk("gpo_b_async_rst", gpo_b, 8'h00);
    model_reset();
    tick();
    resetq = 1;
    repeat (3) tick();
    chk("gpo_b_held", gpo_b, 8'h00);
    io_out = 0;
    tick();
    cpu_out(7, 8'h99);
    chk("gpo_b_rearm", gpo_b, 8'h99);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) io_inp = ~io_inp;
      if ($urandom_range(0, 3) == 0) io_out = ~io_out;
      if (!io_inp && !io_out) io_n = 3'($urandom_range(0, 7));
      io_dout  = 8'($urandom);
      tx_ready = ($urandom_range(0, 2) == 0);
      rx_valid = ($urandom_range(0, 1) == 0);
      rx_data  = 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cdp1802_io_hub.md
Name: cdp1802_io_hub

Overview:
- Parametrised I/O peripheral on the cdp1802 N-line port bus (io_n/io_inp/io_out), the successor to the bare pass-through port plus free-running cycle counter used in the simulation top level.
- Provides a TX stream FIFO, an RX stream FIFO, a sticky status register, two readable output latches and a wide cycle counter with atomic multi-byte snapshot reads.
- Sits between the CPU I/O pins and the test/board environment.

Parameters:
- FIFO_DEPTH, 8: entries per FIFO; power of two, 2..256.
- CC_WIDTH, 16: cycle counter width; multiple of 8, 8..32.

Ports:
- clock  in  1  system clock
- resetq  in  1  asynchronous active-low reset
- io_n  in  3  port number from CPU
- io_inp  in  1  CPU input strobe (INP instruction)
- io_out  in  1  CPU output strobe (OUT instruction)
- io_dout  in  8  data from CPU on OUT
- io_din  out  8  data to CPU on INP
- tx_data  out  8  TX FIFO head
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  sink accepts tx_data
- rx_data  in  8  byte from environment
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  RX FIFO not full
- gpo_a  out  8  output latch A
- gpo_b  out  8  output latch B
- cc  out  CC_WIDTH  free-running cycle counter

Behaviour:
- Reset (resetq=0, asynchronous): both FIFOs empty, sticky bits 0, gpo_a=gpo_b=0x00, cc=0, snapshot=0, strobe edge registers=0. Resulting outputs: tx_valid=0, rx_ready=1, io_din=0x00.
- cc increments by 1 every clock and wraps from all-ones to 0.
- Access rule: side effects occur only on the first cycle of an io_inp or io_out assertion, detected by comparing with the registered previous strobe value. A strobe held N cycles counts as one access. If io_inp and io_out are both high, the cycle is ignored; no side effects and io_din=0x00.
- io_din is combinational from io_n and current state while io_inp=1, and 0x00 otherwise. Read side effects commit at the clock edge ending the access cycle.
- Port map (OUT / INP):
  - 0: ignored / 0x00.
  - 1: push io_dout to TX FIFO / 0x00.
  - 2: ignored / pop RX FIFO and return its head; if RX is empty, return 0x00 with no pop.
  - 3: clear sticky bits where io_dout bit=1 / status {4'b0, tx_ovf, rx_ovf, tx_full, rx_nonempty}.
  - 4: ignored / return cc[7:0] and latch snapshot <= cc[CC_WIDTH-1:8] from the same cycle.
  - 5: ignored / return snapshot[7:0], then shift snapshot right by 8 with zero fill.
  - 6: gpo_a <= io_dout / return gpo_a.
  - 7: gpo_b <= io_dout / return gpo_b.
- TX FIFO:
  - Pop when tx_valid&&tx_ready.
  - A CPU push is accepted iff count<FIFO_DEPTH before this edge; a pop in the same cycle does not make room.
  - A rejected push sets tx_ovf; data is dropped.
  - Push and pop in the same cycle with 0<count<DEPTH: count unchanged, order preserved.
  - A push into an empty FIFO appears on tx_data/tx_valid the next cycle.
- RX FIFO:
  - rx_ready = (count<FIFO_DEPTH).
  - Push when rx_valid&&rx_ready.
  - rx_valid while full sets rx_ovf and drops the byte.
  - CPU pop and environment push may coincide.
- Sticky bits:
  - A set event and an OUT 3 clear in the same cycle: the set wins.
- Pointers are log2(FIFO_DEPTH) bits wrapping modulo depth; the count register is one bit wider.
- Reset mid-access discards the access; on release, a still-high strobe does not count as a new access until it deasserts and reasserts. To achieve this, the edge registers load 1 on the first edge after reset if the strobe is high.

Test Plan:
- Reset then idle: io_din=0x00, tx_valid=0, rx_ready=1, gpo_a=gpo_b=0x00; cc=5 after 5 clocks.
- OUT 1 of 0x11,0x22,0x33 with tx_ready=0, then tx_ready=1 -> tx_data sequence 0x11,0x22,0x33; tx_valid drops after the third pop.
- FIFO_DEPTH=8: nine OUT 1 with tx_ready=0 -> ninth byte dropped and INP 3 = 0x0A (tx_ovf|tx_full). OUT 3 with 0x08 -> INP 3 = 0x02.
- Push rx 0xA5,0x5A, then INP 2 held 3 cycles, then a second INP 2 -> returns 0xA5 then 0x5A, exactly two pops. A third INP 2 returns 0x00; INP 3 bit0=0.
- CC_WIDTH=16, cc=0x12FF at INP 4 -> io_din=0xFF; INP 5 issued 10 cycles later -> 0x12, unaffected by the carry.
- OUT 6 of 0x3C with io_inp also high -> gpo_a stays 0x00. OUT 6 alone -> gpo_a=0x3C, INP 6 = 0x3C. Assert resetq low mid-OUT 7 -> gpo_b=0x00 immediately.
